pipo: RTL and testbench
=======================

Name: pipo

Overview:
- pipo is a parallel-in, parallel-out (PIPO) register: captures the full input word on every rising clock edge and presents it on the output one cycle later.
- Used as a generic pipeline or holding stage wherever a word must be registered with a known reset state.
- Single clock domain; no handshake and no enable.

Parameters:
- WIDTH, 4, data width in bits of in and out; must be ≥ 1.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into out while reset is asserted.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in  input  WIDTH  parallel data word, sampled every rising edge of clk.
- out  output  WIDTH  registered data word.

Behaviour:
- Reset:
  - reset=1 forces out=RESET_VALUE (default 0) immediately, independent of clk.
  - While reset is held, out stays at RESET_VALUE; in is ignored, including X/Z on in.
- Reset release:
  - Deassertion takes effect from the first rising clk edge at which reset is sampled low.
  - No extra synchronisation cycle inside the block; reset-release timing is the integrator's responsibility.
- Normal operation (reset=0):
  - On every rising edge of clk, out <= in (all WIDTH bits in parallel).
  - Bit i of out always comes from bit i of in; no shifting, reordering or inversion.
- Latency:
  - Exactly 1 clock. A value present on in at rising edge N appears on out after edge N and holds until edge N+1.
- Hold:
  - Between rising edges, out is stable regardless of activity on in; no combinational path from in to out.
- Repeated values: loading the same word on consecutive edges leaves out unchanged.
- Simultaneous events: if reset is asserted in the same timestep as a rising clk edge, reset wins and out=RESET_VALUE.
- Reset mid-operation: asserting reset at any time overrides stored data immediately. The word captured before reset is lost.
- Unknown input: if in carries X with reset=0 at a rising edge, out takes X on those bits. No masking is performed.
- Width rules:
  - in and out are the same width; no truncation or extension.
  - RESET_VALUE is truncated or zero-extended to WIDTH.
- Output is driven directly by flip-flops (glitch-free register output).

Test Plan:
- Reset at start:
  - Stimulus: reset=1 for t=0..10 (clk period 10, first rising edge at t=5), in=X.
  - Required: out=0000 throughout reset, including across the edge at t=5.
- Basic load sequence, reset=0 from t=10:
  - in=1111 at t=10 → out=1111 after edge t=15.
  - in=1101 at t=20 → out=1101 after edge t=25.
  - in=0001 at t=30 → out=0001 after edge t=35.
  - in=1100 at t=40 → out=1100 after edge t=45, held through t=80.
- Latency/hold:
  - Change in midway between edges (e.g. 1010 → 0101 at a falling edge).
  - Required: out does not change until the next rising edge, then equals 0101.
- Asynchronous reset mid-stream:
  - With out=1101, pulse reset=1 for 3 time units away from any clk edge.
  - Required: out=0000 immediately on assertion. Next edge after release with in=0110 → out=0110.
- Reset coincident with clk edge:
  - Assert reset in the same timestep as a rising edge with in=1111.
  - Required: out=0000.
- Parameter sweep:
  - WIDTH=8, RESET_VALUE=8'hA5.
  - Required: out=A5 during reset. in=3C → out=3C one cycle later; all 8 bits pass straight through.

Source files
------------

// File: rtl/pipo.sv
// pipo: parallel-in parallel-out register. Captures the full input word
// on every rising clock edge and presents it on the output one cycle later.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset; forces out to RESET_VALUE
//   in    - WIDTH-bit data word, sampled on every rising edge of clk
//   out   - WIDTH-bit registered data word, driven directly by flops
`timescale 1ns/1ps

module pipo #(
  parameter int                 WIDTH       = 4,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] r_out;

  // Reset sits in the sensitivity list, so it wins over a coincident
  // clock edge and clears the stored word without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= RESET_VALUE;
    end else begin
      r_out <= in;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_pipo.sv
// tb_pipo: directed bench for pipo, covering the default 4-bit build
// and an 8-bit build with a non-zero reset value.
`timescale 1ns/1ps

module tb_pipo;

  logic       clk;
  logic       reset;
  logic [3:0] in4;
  logic [3:0] out4;
  logic [7:0] in8;
  logic [7:0] out8;

  int n_tests = 0;
  int n_fail  = 0;

  pipo u_dut4 (
    .clk   (clk),
    .reset (reset),
    .in    (in4),
    .out   (out4)
  );

  pipo #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .in    (in8),
    .out   (out8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  task automatic at(input longint t);
    if (t > $time) #(t - $time);
  endtask

  initial begin
    reset = 1'b1;
    in4   = 4'bxxxx;
    in8   = 8'hxx;

    at(1);
    chk("rst4_t1", {4'h0, out4}, 8'h00);
    chk("rst8_t1", out8, 8'hA5);
    at(6);
    chk("rst4_edge5", {4'h0, out4}, 8'h00);
    chk("rst8_edge5", out8, 8'hA5);

    at(10);
    reset = 1'b0;
    in4   = 4'b1111;
    in8   = 8'h3C;
    at(14);
    chk("hold4_pre15", {4'h0, out4}, 8'h00);
    chk("hold8_pre15", out8, 8'hA5);
    at(16);
    chk("load_1111", {4'h0, out4}, 8'h0F);
    chk("load8_3C", out8, 8'h3C);

    at(20);
    in4 = 4'b1101;
    in8 = 8'hC3;
    at(26);
    chk("load_1101", {4'h0, out4}, 8'h0D);
    chk("load8_C3", out8, 8'hC3);

    at(30);
    in4 = 4'b0001;
    in8 = 8'h81;
    at(36);
    chk("load_0001", {4'h0, out4}, 8'h01);
    chk("load8_81", out8, 8'h81);

    at(40);
    in4 = 4'b1100;
    at(46);
    chk("load_1100", {4'h0, out4}, 8'h0C);
    at(56);
    chk("repeat_1100", {4'h0, out4}, 8'h0C);
    at(80);
    chk("held_1100_t80", {4'h0, out4}, 8'h0C);

    in4 = 4'b1010;
    at(86);
    chk("load_1010", {4'h0, out4}, 8'h0A);
    at(90);
    in4 = 4'b0101;
    at(94);
    chk("hold_mid_1010", {4'h0, out4}, 8'h0A);
    at(96);
    chk("load_0101", {4'h0, out4}, 8'h05);

    at(100);
    in4 = 4'b1101;
    at(106);
    chk("pre_rst_1101", {4'h0, out4}, 8'h0D);
    at(108);
    reset = 1'b1;
    at(109);
    chk("async_rst4", {4'h0, out4}, 8'h00);
    chk("async_rst8", out8, 8'hA5);
    at(111);
    reset = 1'b0;
    in4   = 4'b0110;
    at(114);
    chk("post_rst_hold", {4'h0, out4}, 8'h00);
    at(116);
    chk("post_rst_0110", {4'h0, out4}, 8'h06);

    at(120);
    in4 = 4'b1111;
    at(125);
    reset = 1'b1;
    at(126);
    chk("coinc_rst", {4'h0, out4}, 8'h00);
    at(136);
    chk("held_rst_edge", {4'h0, out4}, 8'h00);
    at(138);
    reset = 1'b0;
    at(146);
    chk("post_coinc_1111", {4'h0, out4}, 8'h0F);

    at(150);
    in4 = 4'b10x1;
    at(156);
    chk("x_passthru", {4'h0, out4}, {4'h0, 4'b10x1});

    at(160);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
